// File: rtl/acc_drain.sv
// acc_drain: mirrors the per-channel accumulator RAM write counts, reads
// completed x/y pairs back through the dsp-clock RAM port and streams them
// out on a valid/ready interface with round-robin channel arbitration.
module acc_drain #(
    parameter int NCH    = 4,
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int RDLAT  = 2,
    parameter int FDEPTH = 4,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [NCH-1:0]    wr_stb_i,
    output logic              rd_en_o,
    output logic [NCH-1:0]    rd_sel_o,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [NCH*DW-1:0] rd_data_i,
    output logic [DW-1:0]     m_data_o,
    output logic [CW-1:0]     m_chan_o,
    output logic              m_last_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam int FPW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int FCW = $clog2(FDEPTH + 1);

    typedef enum logic [1:0] {ARB, RD0, RD1} state_t;

    state_t                  state_q;
    logic [NCH-1:0][AW:0]    wcnt_q, rcnt_q;
    logic [CW-1:0]           rr_q, g_q;
    logic                    rd_en_q;
    logic [NCH-1:0]          rd_sel_q;
    logic [AW-1:0]           rd_addr_q;

    // read-return tag pipe: index 0 is the newest read, RDLAT-1 returns now
    logic [RDLAT-1:0]          tag_vld_q, tag_last_q;
    logic [RDLAT-1:0][CW-1:0]  tag_chan_q;

    logic [DW-1:0]  fdat_q  [FDEPTH];
    logic [CW-1:0]  fchan_q [FDEPTH];
    logic           flast_q [FDEPTH];
    logic [FPW-1:0] fwp_q, frp_q;
    logic [FCW-1:0] fcnt_q;

    logic [NCH-1:0] elig;
    logic           gnt_found;
    logic [CW-1:0]  gnt_idx;
    logic           fifo_push, fifo_pop;
    logic [DW-1:0]  push_data;

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // write-count mirror; saturates at DEPTH so a full RAM is drained exactly once
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset_i || start_i)
                wcnt_q[c] <= '0;
            else if (wr_stb_i[c] && wcnt_q[c] != DEPTH)
                wcnt_q[c] <= wcnt_q[c] + 1'b1;
        end
    end

    // eligibility (whole pair written, room for both words) and RR pick
    always_comb begin
        int nfl;
        int idx;
        nfl       = 0;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int s = 0; s < RDLAT; s++)
            nfl = nfl + int'(tag_vld_q[s]);
        for (int c = 0; c < NCH; c++)
            elig[c] = ((FDEPTH - int'(fcnt_q) - nfl) >= 2) &&
                      ((wcnt_q[c] - rcnt_q[c]) >= (AW+1)'(2));
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_q) + i) % NCH;
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'(idx);
            end
        end
    end

    // arbitration / pair-read FSM with registered RAM read outputs
    always_ff @(posedge clk_i) begin
        if (reset_i || start_i) begin
            state_q   <= ARB;
            rr_q      <= '0;
            g_q       <= '0;
            rcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_sel_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            case (state_q)
                ARB: if (gnt_found) begin
                    g_q       <= gnt_idx;
                    rr_q      <= CW'((int'(gnt_idx) + 1) % NCH);
                    rd_en_q   <= 1'b1;
                    rd_sel_q  <= NCH'(1) << gnt_idx;
                    rd_addr_q <= rcnt_q[gnt_idx][AW-1:0];
                    state_q   <= RD0;
                end
                RD0: begin
                    rcnt_q[g_q] <= rcnt_q[g_q] + 1'b1;
                    rd_addr_q   <= rd_addr_q + 1'b1;
                    state_q     <= RD1;
                end
                RD1: begin
                    rcnt_q[g_q] <= rcnt_q[g_q] + 1'b1;
                    rd_en_q     <= 1'b0;
                    rd_sel_q    <= '0;
                    state_q     <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // tag pipe tracks {valid, chan, last} alongside the RAM read latency
    always_ff @(posedge clk_i) begin
        if (reset_i || start_i) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            tag_chan_q <= '0;
        end else begin
            tag_vld_q  <= RDLAT'({tag_vld_q, rd_en_q});
            tag_last_q <= RDLAT'({tag_last_q, state_q == RD1});
            tag_chan_q <= (RDLAT*CW)'({tag_chan_q, g_q});
        end
    end

    assign fifo_push = tag_vld_q[RDLAT-1];
    assign fifo_pop  = m_valid_o & m_ready_i;
    assign push_data = rd_data_i[int'(tag_chan_q[RDLAT-1])*DW +: DW];

    // output FIFO; start flushes it so stale words never reach the stream
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwp_q  <= '0;
            frp_q  <= '0;
            fcnt_q <= '0;
            for (int i = 0; i < FDEPTH; i++) begin
                fdat_q[i]  <= '0;
                fchan_q[i] <= '0;
                flast_q[i] <= 1'b0;
            end
        end else if (start_i) begin
            fwp_q  <= '0;
            frp_q  <= '0;
            fcnt_q <= '0;
        end else begin
            if (fifo_push) begin
                fdat_q[fwp_q]  <= push_data;
                fchan_q[fwp_q] <= tag_chan_q[RDLAT-1];
                flast_q[fwp_q] <= tag_last_q[RDLAT-1];
                fwp_q          <= ptr_inc(fwp_q);
            end
            if (fifo_pop)
                frp_q <= ptr_inc(frp_q);
            fcnt_q <= fcnt_q + FCW'(fifo_push) - FCW'(fifo_pop);
        end
    end

    ovf_a: assert property (@(posedge clk_i) disable iff (reset_i || start_i)
                            !(fifo_push && fcnt_q == FCW'(FDEPTH)));

    assign rd_en_o   = rd_en_q;
    assign rd_sel_o  = rd_sel_q;
    assign rd_addr_o = rd_addr_q;
    assign m_valid_o = (fcnt_q != '0);
    assign m_data_o  = fdat_q[frp_q];
    assign m_chan_o  = fchan_q[frp_q];
    assign m_last_o  = flast_q[frp_q];
    assign busy_o    = (state_q != ARB) | (|tag_vld_q) | m_valid_o;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: RAM model with read latency, per-channel scoreboard
// filled on writes and drained by a stream monitor.
module tb_acc_drain;
    localparam int NCH = 4, AW = 12, DW = 32, RDLAT = 2, FDEPTH = 4;
    localparam int DEPTH = 1 << AW;
    localparam int CW = 2;

    logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [NCH-1:0]    wr_stb = '0;
    logic              rd_en;
    logic [NCH-1:0]    rd_sel;
    logic [AW-1:0]     rd_addr;
    logic [NCH*DW-1:0] rd_data;
    logic [DW-1:0]     m_data;
    logic [CW-1:0]     m_chan;
    logic              m_last, m_valid, busy;
    logic              m_ready = 1'b0;

    acc_drain #(.NCH(NCH), .AW(AW), .DW(DW), .RDLAT(RDLAT), .FDEPTH(FDEPTH)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .wr_stb_i(wr_stb),
        .rd_en_o(rd_en), .rd_sel_o(rd_sel), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .m_data_o(m_data), .m_chan_o(m_chan), .m_last_o(m_last), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .busy_o(busy));

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic last; } exp_t;
    exp_t          sbq [NCH][$];
    logic [DW-1:0] ram [NCH][DEPTH];
    int wp [NCH], rexp [NCH];
    int nchk = 0, nerr = 0, nxfer = 0, rdn = 0, cyc = 0, last_addr = -1;
    int chanlog[$], xcyc[$];
    logic [NCH*DW-1:0] rpipe [RDLAT];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM read port model: RDLAT cycles from rd_en to data, unselected slots garbage
    always @(posedge clk) begin
        for (int s = RDLAT - 1; s > 0; s--) rpipe[s] <= rpipe[s-1];
        for (int c = 0; c < NCH; c++)
            rpipe[0][c*DW +: DW] <= (rd_en && rd_sel[c]) ? ram[c][rd_addr] : 32'hDEADBEEF;
    end
    assign rd_data = rpipe[RDLAT-1];

    // monitor: read address sequence per channel, stream words against scoreboard
    always @(negedge clk) begin : mon
        int c;
        exp_t e;
        if (!reset) begin
            if (rd_en) begin
                c = -1;
                for (int i = 0; i < NCH; i++) if (rd_sel[i]) c = i;
                chk("rd_sel_onehot", $onehot(rd_sel), 1);
                if (c >= 0) begin
                    chk("rd_addr", rd_addr, rexp[c] % DEPTH);
                    rexp[c]++;
                end
                rdn++;
                last_addr = rd_addr;
            end
            if (m_valid && m_ready) begin
                nxfer++;
                xcyc.push_back(cyc);
                if (!m_last) chanlog.push_back(int'(m_chan));
                chk("sb_nonempty", sbq[m_chan].size() > 0, 1);
                if (sbq[m_chan].size() > 0) begin
                    e = sbq[m_chan].pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.last);
                end
            end
        end
    end

    task automatic wr(input logic [NCH-1:0] m, input logic [DW-1:0] d);
        for (int c = 0; c < NCH; c++)
            if (m[c] && wp[c] < DEPTH) begin
                ram[c][wp[c]] = d;
                if (wp[c] % 2 == 1) begin
                    sbq[c].push_back('{ram[c][wp[c]-1], 1'b0});
                    sbq[c].push_back('{d, 1'b1});
                end
                wp[c]++;
            end
        wr_stb = m;
        @(posedge clk); #1;
        wr_stb = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sbq[c].delete();
            wp[c] = 0;
            rexp[c] = 0;
        end
        chanlog.delete();
        xcyc.delete();
    endtask

    task automatic wait_quiet(input int lim, input string tag);
        int q;
        q = 0;
        for (int i = 0; i < lim && q < 8; i++) begin
            @(posedge clk); #1;
            if (!busy) q++; else q = 0;
        end
        chk(tag, q >= 8, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2, n0, r0, r1, found;
        for (int c = 0; c < NCH; c++) begin wp[c] = 0; rexp[c] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_sel", rd_sel, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_chan", m_chan, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single pair on channel 1, latency measured from the second strobe
        m_ready = 1'b1;
        wr(4'b0010, 32'h11111111);
        t2 = cyc;
        wr(4'b0010, 32'h22222222);
        wait_quiet(50, "quiet_single");
        chk("single_nxfer", nxfer, 2);
        chk("single_rdn", rdn, 2);
        chk("single_x_cyc", q_at(xcyc, 0), t2 + 5);
        chk("single_y_cyc", q_at(xcyc, 1), t2 + 6);
        chk("single_chan", q_at(chanlog, 0), 1);

        // round-robin across all channels, two pairs each
        do_start();
        n0 = nxfer;
        for (int i = 0; i < 4; i++) wr(4'b1111, 32'hA0000000 + i);
        wait_quiet(200, "quiet_rr");
        chk("rr_nxfer", nxfer - n0, 16);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_grant%0d", i), q_at(chanlog, i), i % 4);

        // backpressure: three pairs on channel 0 with the stream stalled
        do_start();
        m_ready = 1'b0;
        n0 = nxfer; r0 = rdn;
        for (int i = 0; i < 6; i++) wr(4'b0001, 32'hB0000000 + i);
        repeat (30) @(posedge clk);
        chk("bp_reads_le4", (rdn - r0) <= 4, 1);
        chk("bp_reads_ge2", (rdn - r0) >= 2, 1);
        @(negedge clk);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 32'hB0000000);
        chk("bp_last", m_last, 0);
        repeat (5) @(negedge clk);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, 32'hB0000000);
        chk("bp_hold_chan", m_chan, 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_quiet(100, "quiet_bp");
        chk("bp_nxfer", nxfer - n0, 6);
        chk("bp_sb_empty", sbq[0].size(), 0);

        // saturation: more strobes than the RAM holds on channel 2
        do_start();
        n0 = nxfer; r0 = rdn;
        for (int i = 0; i < DEPTH + 4; i++) wr(4'b0100, 32'hC0000000 + i);
        wait_quiet(8000, "quiet_sat");
        chk("sat_nxfer", nxfer - n0, DEPTH);
        chk("sat_reads", rdn - r0, DEPTH);
        chk("sat_last_addr", last_addr, DEPTH - 1);
        r1 = rdn;
        repeat (20) @(posedge clk);
        chk("sat_no_more_reads", rdn, r1);
        chk("sat_sb_empty", sbq[2].size(), 0);

        // start while the second read of a pair is on the RAM port
        do_start();
        for (int i = 0; i < 4; i++) wr(4'b0001, 32'hD0000000 + i);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (rd_en && rd_addr[0]) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_found_rd1", found, 1);
        n0 = nxfer;
        do_start();
        @(negedge clk);
        chk("mid_valid_off", m_valid, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_stale", nxfer - n0, 0);
        wr(4'b0001, 32'hE0000000);
        wr(4'b0001, 32'hE0000001);
        wait_quiet(50, "quiet_mid");
        chk("mid_nxfer", nxfer - n0, 2);
        chk("mid_last_addr", last_addr, 1);

        // odd count: the unpaired word waits for its partner
        do_start();
        n0 = nxfer;
        for (int i = 0; i < 3; i++) wr(4'b1000, 32'hF0000000 + i);
        wait_quiet(50, "quiet_odd");
        repeat (10) @(posedge clk);
        #1;
        chk("odd_one_pair", nxfer - n0, 2);
        wr(4'b1000, 32'hF0000003);
        wait_quiet(50, "quiet_odd2");
        chk("odd_two_pairs", nxfer - n0, 4);
        chk("odd_sb_empty", sbq[3].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
